// File: rtl/scan_pattern_ctrl.sv
// Scan pattern controller: loads one parallel pattern serially into a downstream
// scan chain, pulses a capture window, unloads the response and tallies pass/fail.
module scan_pattern_ctrl #(
    parameter int CHAIN_LEN      = 3,
    parameter int CAPTURE_CYCLES = 1,
    parameter int CNT_W          = 8
) (
    input  logic                 ScanClk,
    input  logic                 ScanClrN,
    input  logic                 PatValid,
    output logic                 PatReady,
    input  logic [CHAIN_LEN-1:0] PatData,
    input  logic [CHAIN_LEN-1:0] PatExpect,
    input  logic                 Abort,
    output logic                 ScanMode,
    output logic                 ScanIn,
    input  logic                 ScanOut,
    output logic                 RespValid,
    input  logic                 RespReady,
    output logic [CHAIN_LEN-1:0] RespData,
    output logic                 RespMismatch,
    output logic [CNT_W-1:0]     PassCount,
    output logic [CNT_W-1:0]     FailCount
);
    localparam int CW = $clog2(CHAIN_LEN + CAPTURE_CYCLES + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SHIFT_IN  = 3'd1;
    localparam logic [2:0] CAPTURE   = 3'd2;
    localparam logic [2:0] SHIFT_OUT = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] shreg;
    logic [CHAIN_LEN-1:0] expect_q;
    logic [CHAIN_LEN-1:0] resp_next;
    logic                 busy;

    // First unloaded bit is the chain tail; it ends up in the MSB after CHAIN_LEN shifts.
    assign resp_next = {RespData[CHAIN_LEN-2:0], ScanOut};
    assign busy      = (state == SHIFT_IN) || (state == CAPTURE) || (state == SHIFT_OUT);

    always_ff @(posedge ScanClk or negedge ScanClrN) begin
        if (!ScanClrN) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            expect_q     <= '0;
            PatReady     <= 1'b1;
            ScanMode     <= 1'b0;
            ScanIn       <= 1'b0;
            RespValid    <= 1'b0;
            RespData     <= '0;
            RespMismatch <= 1'b0;
            PassCount    <= '0;
            FailCount    <= '0;
        end else if (Abort && busy) begin
            state     <= IDLE;
            ScanMode  <= 1'b0;
            ScanIn    <= 1'b0;
            PatReady  <= 1'b1;
            RespValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (PatValid && PatReady) begin
                        shreg    <= PatData;
                        expect_q <= PatExpect;
                        ScanMode <= 1'b1;
                        ScanIn   <= PatData[CHAIN_LEN-1];
                        PatReady <= 1'b0;
                        cnt      <= CW'(CHAIN_LEN - 1);
                        state    <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    if (cnt == '0) begin
                        ScanMode <= 1'b0;
                        ScanIn   <= 1'b0;
                        cnt      <= CW'(CAPTURE_CYCLES - 1);
                        state    <= CAPTURE;
                    end else begin
                        // MSB-first: the next bit to drive always sits just below the top.
                        ScanIn <= shreg[CHAIN_LEN-2];
                        shreg  <= {shreg[CHAIN_LEN-2:0], 1'b0};
                        cnt    <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cnt == '0) begin
                        ScanMode <= 1'b1;
                        ScanIn   <= 1'b0;
                        cnt      <= CW'(CHAIN_LEN - 1);
                        state    <= SHIFT_OUT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT_OUT: begin
                    RespData <= resp_next;
                    if (cnt == '0) begin
                        ScanMode     <= 1'b0;
                        RespValid    <= 1'b1;
                        RespMismatch <= (resp_next != expect_q);
                        if (resp_next != expect_q) begin
                            if (FailCount != '1) FailCount <= FailCount + 1'b1;
                        end else begin
                            if (PassCount != '1) PassCount <= PassCount + 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        PatReady  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/scan_pattern_ctrl.md
Name: scan_pattern_ctrl

Overview:
Scan test controller that sits directly upstream of the scan-equipped design top. It drives that top's ScanMode and ScanIn inputs. It accepts one parallel test pattern per handshake, shifts the pattern serially into the scan chain, and pulses one functional capture window. It then shifts the captured state back out through the chain tail. Each unloaded response is presented as a parallel word with a compare flag against an expected word, and pass/fail tallies are kept.

Parameters:
CHAIN_LEN, 3, number of flops in the downstream scan chain (>= 2)
CAPTURE_CYCLES, 1, cycles ScanMode is held low for functional capture (1..4)
CNT_W, 8, width of the pass/fail tally counters

Ports:
ScanClk  in  1  block clock; same clock as the downstream scan chain
ScanClrN  in  1  asynchronous active-low reset
PatValid  in  1  pattern offer
PatReady  out  1  controller can accept a pattern
PatData  in  CHAIN_LEN  stimulus to load; bit k lands in chain flop k (flop CHAIN_LEN-1 = tail)
PatExpect  in  CHAIN_LEN  expected captured chain state, same bit mapping
Abort  in  1  synchronous abort of the current pattern
ScanMode  out  1  to downstream ScanMode; 1 = shift, 0 = functional/capture
ScanIn  out  1  to downstream ScanIn
ScanOut  in  1  chain tail value from downstream
RespValid  out  1  response available
RespReady  in  1  response consumed
RespData  out  CHAIN_LEN  unloaded chain state, same bit mapping as PatData
RespMismatch  out  1  RespData != latched PatExpect
PassCount  out  CNT_W  saturating count of matching responses
FailCount  out  CNT_W  saturating count of mismatching responses

Behaviour:
- Reset (ScanClrN=0, asynchronous): state IDLE; PatReady=1; ScanMode=0; ScanIn=0; RespValid=0; RespData=0; RespMismatch=0; PassCount=0; FailCount=0.
- All outputs are registered. The chain samples ScanMode/ScanIn on the ScanClk edge after the controller drives them.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, RESP.
- IDLE: PatReady=1. On PatValid&PatReady at edge t0:
  - latch PatData into the shift register and PatExpect into the expect register
  - go to SHIFT_IN; ScanMode=1; ScanIn=PatData[CHAIN_LEN-1]; PatReady=0
- SHIFT_IN: CHAIN_LEN cycles. On each subsequent edge, ScanIn takes the next lower bit, so bits go out MSB first and bit 0 is driven last. A down-counter tracks remaining bits. At edge t0+CHAIN_LEN go to CAPTURE with ScanMode=0 and ScanIn=0.
- CAPTURE: ScanMode=0 for exactly CAPTURE_CYCLES cycles, then go to SHIFT_OUT with ScanMode=1 and ScanIn=0.
- SHIFT_OUT: CHAIN_LEN cycles. On each edge, RespData <= {RespData[CHAIN_LEN-2:0], ScanOut}; the first bit sampled is the tail value, which ends in bit CHAIN_LEN-1. After CHAIN_LEN samples:
  - ScanMode=0, RespValid=1
  - RespMismatch = (RespData != expect), using the final value
  - PassCount or FailCount increments, saturating at all-ones
  - go to RESP
- Latency: RespValid rises at edge t0+2*CHAIN_LEN+CAPTURE_CYCLES (7 cycles for the defaults).
- RESP: RespValid and RespData are held stable until RespValid&RespReady. On that edge: RespValid=0, PatReady=1, go to IDLE.
  - PatReady stays 0 in RESP, so there is no pattern overlap.
  - A pattern offered in the same cycle as the response handshake is accepted on the following edge at the earliest.
- Abort=1 in SHIFT_IN, CAPTURE or SHIFT_OUT: on the next edge go to IDLE with ScanMode=0, ScanIn=0, PatReady=1, RespValid=0. Counters are unchanged and no response is produced.
- Abort in IDLE or RESP has no effect. Abort has priority over the state transitions in the same cycle.
- Reset asserted mid-operation: immediate return to the reset values; counters clear.
- PatValid while PatReady=0 is ignored; PatData/PatExpect are only sampled at acceptance.
- Counters only change on the cycle RespValid rises.

Test Plan:
- Reset mid-SHIFT_IN (ScanClrN low for 1 cycle after 2 shifts) -> ScanMode=0, PatReady=1, counters 0 immediately; next pattern runs a normal 7-cycle sequence.
- CHAIN_LEN=3, behavioural chain capturing a constant 3'b110; PatData=3'b101, PatExpect=3'b110:
  - ScanIn sequence 1,0,1 with ScanMode=1 for 3 cycles
  - ScanMode=0 for 1 cycle
  - RespValid at t0+7 with RespData=3'b110, RespMismatch=0, PassCount=1
- Same chain, PatExpect=3'b011 -> RespData=3'b110, RespMismatch=1, FailCount=1, PassCount unchanged.
- RespReady held 0 for 5 cycles -> RespValid/RespData stable, PatReady=0, a new PatValid is ignored; RespReady=1 -> PatReady=1 next cycle.
- Abort=1 during the 2nd SHIFT_OUT cycle -> IDLE next edge, ScanMode=0, no RespValid, counters unchanged.
- CNT_W=2, 5 matching patterns back-to-back -> PassCount saturates at 3.
